// File: rtl/string_hw_arbiter.sv
// Two-requester round-robin arbiter fronting a shared string engine.
// Optional BUSY watchdog enabled by defining STRING_HW_ARB_TIMEOUT_EN.
module string_hw_arbiter #(
    parameter int SIZE           = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [SIZE*8-1:0]   req_a0,
    input  logic [SIZE*8-1:0]   req_a1,
    input  logic [SIZE*8-1:0]   req_b0,
    input  logic [SIZE*8-1:0]   req_b1,
    input  logic [2:0]          req_index0,
    input  logic [2:0]          req_index1,
    input  logic [2:0]          req_length0,
    input  logic [2:0]          req_length1,
    output logic [1:0]          gnt,
    output logic [1:0]          rsp_valid,
    output logic [SIZE*8-1:0]   rsp_result,
    output logic                rsp_err,
    output logic                busy,
    output logic                eng_go,
    output logic [SIZE*8-1:0]   eng_a,
    output logic [SIZE*8-1:0]   eng_b,
    output logic [2:0]          eng_index,
    output logic [2:0]          eng_length,
    input  logic                eng_done,
    input  logic [SIZE*8-1:0]   eng_result
);

    localparam int W = SIZE * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_q, last_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2:0]     index_q, index_d;
    logic [2:0]     length_q, length_d;
    logic [W-1:0]   res_q, res_d;
    logic           win;
    logic [1:0]     owner_oh;

`ifdef STRING_HW_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic           err_q, err_d;
    logic [7:0]     cnt_q, cnt_d;
`endif

    // Round-robin pick: a lone request wins, a tie goes to the one not served last.
    assign win = req[1] & (~req[0] | ~last_q);

    // Next-state and datapath capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        index_d  = index_q;
        length_d = length_q;
        res_d    = res_q;
`ifdef STRING_HW_ARB_TIMEOUT_EN
        err_d    = err_q;
        cnt_d    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d  = win;
                    a_d      = win ? req_a1 : req_a0;
                    b_d      = win ? req_b1 : req_b0;
                    index_d  = win ? req_index1 : req_index0;
                    length_d = win ? req_length1 : req_length0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    res_d   = eng_result;
                    last_d  = owner_q;
                    state_d = RESP;
`ifdef STRING_HW_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            RESP: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!eng_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-data registers; pointer resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            index_q  <= '0;
            length_q <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            index_q  <= index_d;
            length_q <= length_d;
            res_q    <= res_d;
        end
    end

`ifdef STRING_HW_ARB_TIMEOUT_EN
    // Watchdog counter and error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign owner_oh   = owner_q ? 2'b10 : 2'b01;
    assign busy       = (state_q != IDLE);
    assign eng_go     = (state_q == BUSY);
    assign gnt        = (state_q == BUSY || state_q == RESP) ? owner_oh : 2'b00;
    assign rsp_valid  = (state_q == RESP) ? owner_oh : 2'b00;
    assign rsp_result = res_q;
    assign eng_a      = a_q;
    assign eng_b      = b_q;
    assign eng_index  = index_q;
    assign eng_length = length_q;

endmodule

// File: tb/tb_string_hw_arbiter.sv
// Scoreboard bench for string_hw_arbiter: directed transactions,
// round-robin, drain hold, async reset and watchdog behaviour.
module tb_string_hw_arbiter;

    localparam int W = 32;

    localparam logic [W-1:0] A0 = 32'h41424344;
    localparam logic [W-1:0] A1 = 32'h55667788;
    localparam logic [W-1:0] B0 = 32'h01020304;
    localparam logic [W-1:0] B1 = 32'hA0B0C0D0;
    localparam logic [2:0]   I0 = 3'd2;
    localparam logic [2:0]   L0 = 3'd3;
    localparam logic [2:0]   I1 = 3'd5;
    localparam logic [2:0]   L1 = 3'd1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [1:0]     req = 2'b00;
    logic [W-1:0]   req_a0 = A0;
    logic [W-1:0]   req_a1 = A1;
    logic [W-1:0]   req_b0 = B0;
    logic [W-1:0]   req_b1 = B1;
    logic [2:0]     req_index0 = I0;
    logic [2:0]     req_index1 = I1;
    logic [2:0]     req_length0 = L0;
    logic [2:0]     req_length1 = L1;
    logic [1:0]     gnt;
    logic [1:0]     rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_err;
    logic           busy;
    logic           eng_go;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic [2:0]     eng_index;
    logic [2:0]     eng_length;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_result = '0;

    typedef struct packed {
        logic [1:0]   v;
        logic [W-1:0] r;
        logic         e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    string_hw_arbiter #(
        .SIZE(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_a0(req_a0),
        .req_a1(req_a1),
        .req_b0(req_b0),
        .req_b1(req_b1),
        .req_index0(req_index0),
        .req_index1(req_index1),
        .req_length0(req_length0),
        .req_length1(req_length1),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_result(rsp_result),
        .rsp_err(rsp_err),
        .busy(busy),
        .eng_go(eng_go),
        .eng_a(eng_a),
        .eng_b(eng_b),
        .eng_index(eng_index),
        .eng_length(eng_length),
        .eng_done(eng_done),
        .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none",
                         rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, mon_e.v});
                chk("rsp_result", {32'd0, rsp_result}, {32'd0, mon_e.r});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e.e});
            end
        end
    end

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got gnt=00 expected a grant");
        end
    endtask

    task automatic do_txn(input logic [1:0] r, input logic [1:0] eg,
                          input int dly, input logic [W-1:0] res,
                          input int hold, input logic [1:0] nreq,
                          input bit mutate);
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [2:0]   ei;
        logic [2:0]   el;
        bit           ok;
        ea = eg[1] ? A1 : A0;
        eb = eg[1] ? B1 : B0;
        ei = eg[1] ? I1 : I0;
        el = eg[1] ? L1 : L0;
        req = r;
        sb.push_back('{eg, res, 1'b0});
        wait_gnt(ok);
        if (!ok) return;
        chk("gnt", {62'd0, gnt}, {62'd0, eg});
        chk("eng_go", {63'd0, eng_go}, 64'd1);
        chk("eng_a", {32'd0, eng_a}, {32'd0, ea});
        chk("eng_b", {32'd0, eng_b}, {32'd0, eb});
        chk("eng_index", {61'd0, eng_index}, {61'd0, ei});
        chk("eng_length", {61'd0, eng_length}, {61'd0, el});
        if (mutate) begin
            req_a0 = ~A0;
            req_a1 = ~A1;
            req_index0 = ~I0;
            req = 2'b00;
        end
        repeat (dly - 1) @(negedge clk);
        chk("eng_a_held", {32'd0, eng_a}, {32'd0, ea});
        chk("eng_index_held", {61'd0, eng_index}, {61'd0, ei});
        chk("busy_go", {63'd0, eng_go}, 64'd1);
        eng_done = 1'b1;
        eng_result = res;
        @(negedge clk);
        chk("resp_go", {63'd0, eng_go}, 64'd0);
        req = nreq;
        req_a0 = A0;
        req_a1 = A1;
        req_index0 = I0;
        eng_result = 32'hBAD0BAD0;
        if (hold == 0) eng_done = 1'b0;
        @(negedge clk);
        chk("drain_gnt", {62'd0, gnt}, 64'd0);
        chk("drain_busy", {63'd0, busy}, 64'd1);
        chk("drain_result", {32'd0, rsp_result}, {32'd0, res});
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("drain_hold_gnt", {62'd0, gnt}, 64'd0);
            chk("drain_hold_busy", {63'd0, busy}, 64'd1);
        end
        eng_done = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit ok;
        int n;
        #2;
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_eng_go", {63'd0, eng_go}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_eng_a", {32'd0, eng_a}, 64'd0);
        chk("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_txn(2'b11, 2'b01, 3, 32'h000000A1, 0, 2'b11, 1'b0);
        do_txn(2'b11, 2'b10, 4, 32'h000000A2, 0, 2'b11, 1'b0);
        do_txn(2'b11, 2'b01, 2, 32'h000000A3, 0, 2'b00, 1'b0);

        do_txn(2'b01, 2'b01, 5, 32'h11223344, 0, 2'b00, 1'b1);

        do_txn(2'b10, 2'b10, 3, 32'h5555AAAA, 3, 2'b10, 1'b0);
        do_txn(2'b10, 2'b10, 2, 32'h00000F0F, 0, 2'b00, 1'b0);

        req = 2'b01;
        wait_gnt(ok);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", {62'd0, gnt}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_eng_go", {63'd0, eng_go}, 64'd0);
        chk("arst_eng_a", {32'd0, eng_a}, 64'd0);
        chk("arst_eng_index", {61'd0, eng_index}, 64'd0);
        chk("arst_rsp_result", {32'd0, rsp_result}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        req = 2'b00;
        repeat (3) @(negedge clk);

        do_txn(2'b10, 2'b10, 2, 32'h0000CAFE, 0, 2'b00, 1'b0);
        do_txn(2'b11, 2'b01, 2, 32'h0000BEEF, 0, 2'b00, 1'b0);

`ifdef STRING_HW_ARB_TIMEOUT_EN
        sb.push_back('{2'b01, 32'h0, 1'b1});
        req = 2'b01;
        wait_gnt(ok);
        req = 2'b00;
        n = 1;
        while (rsp_valid == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 64'(n - 1), 64'd8);
        repeat (2) @(negedge clk);
        chk("timeout_idle", {63'd0, busy}, 64'd0);
`else
        n = 0;
        req = 2'b01;
        wait_gnt(ok);
        req = 2'b00;
        repeat (300) @(negedge clk);
        chk("stuck_busy", {63'd0, busy}, 64'd1);
        chk("stuck_go", {63'd0, eng_go}, 64'd1);
        chk("stuck_gnt", {62'd0, gnt}, 64'd1);
        chk("stuck_err", {63'd0, rsp_err}, 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
